// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl: job sequencer for the MAC unit's 8x8 multiplier.
// Streams len_i unsigned operand pairs through one multiplier and a product
// register, sums the products into an ACC_W-bit accumulator, then presents
// the result on a valid/ready port.
// Build option: define MAC_SAT_EN to saturate the accumulator on carry out
// (default build wraps modulo 2^ACC_W; ovf_o is set in both builds).

// Dadda_Mult8_1: unsigned 8x8 multiplier.
// The eight partial-product rows are reduced with row-level 3:2 compressors
// following the Dadda height schedule 8 -> 6 -> 4 -> 3 -> 2, then one final
// carry-propagate add. Every stage is exact modulo 2^16, and the true product
// always fits in 16 bits.
module Dadda_Mult8_1 (
  input  logic [7:0]  a_i,
  input  logic [7:0]  b_i,
  output logic [15:0] p_o
);

  logic [15:0] pp [8];
  logic [15:0] s1a, c1a, s1b, c1b;
  logic [15:0] s2a, c2a, s2b, c2b;
  logic [15:0] s3, c3, s4, c4;

  function automatic logic [15:0] csa_carry(logic [15:0] x, logic [15:0] y, logic [15:0] z);
    return ((x & y) | (x & z) | (y & z)) << 1;
  endfunction

  // partial-product generation, row i weighted by 2^i
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      pp[i] = {8'b0, a_i & {8{b_i[i]}}} << i;
    end
  end

  // 8 -> 6 rows
  assign s1a = pp[0] ^ pp[1] ^ pp[2];
  assign c1a = csa_carry(pp[0], pp[1], pp[2]);
  assign s1b = pp[3] ^ pp[4] ^ pp[5];
  assign c1b = csa_carry(pp[3], pp[4], pp[5]);
  // 6 -> 4 rows
  assign s2a = s1a ^ c1a ^ s1b;
  assign c2a = csa_carry(s1a, c1a, s1b);
  assign s2b = c1b ^ pp[6] ^ pp[7];
  assign c2b = csa_carry(c1b, pp[6], pp[7]);
  // 4 -> 3 rows
  assign s3  = s2a ^ c2a ^ s2b;
  assign c3  = csa_carry(s2a, c2a, s2b);
  // 3 -> 2 rows
  assign s4  = s3 ^ c3 ^ c2b;
  assign c4  = csa_carry(s3, c3, c2b);

  assign p_o = s4 + c4;

endmodule

// state | meaning
// IDLE  | waiting for start_i; accumulator holds the previous result
// RUN   | accepting operand pairs, one per cycle while in_valid_i
// DRAIN | last product still in prod_q, accumulated on this edge
// DONE  | result offered on out_valid_o until out_ready_i
module mac_seq_ctrl #(
  parameter int ACC_W = 24,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [LEN_W-1:0] len_i,
  output logic             busy_o,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [7:0]       a_i,
  input  logic [7:0]       b_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [ACC_W-1:0] acc_out_o,
  output logic             ovf_o
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [15:0]      prod_q, prod_d;
  logic             prod_v_q, prod_v_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;

  logic [15:0]      prod_w;
  logic [ACC_W:0]   sum_w;
  logic             start_w, accept_w, last_w;

  Dadda_Mult8_1 u_mult (
    .a_i (a_i),
    .b_i (b_i),
    .p_o (prod_w)
  );

  assign start_w  = (state_q == IDLE) && start_i;
  assign accept_w = (state_q == RUN) && in_valid_i;
  assign last_w   = accept_w && (cnt_q == len_q - 1'b1);
  // the extra top bit of the sum is the carry out of the accumulator
  assign sum_w    = {1'b0, acc_q} + (ACC_W+1)'(prod_q);

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = (len_i == '0) ? DONE : RUN;
      RUN:     if (last_w) state_d = DRAIN;
      DRAIN:   state_d = DONE;
      DONE:    if (out_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // state-decoded outputs
  always_comb begin
    busy_o      = (state_q != IDLE);
    in_ready_o  = (state_q == RUN);
    out_valid_o = (state_q == DONE);
  end

  // datapath next values: job setup, product capture, accumulation
  always_comb begin
    len_d    = len_q;
    cnt_d    = cnt_q;
    prod_d   = prod_q;
    prod_v_d = 1'b0;
    acc_d    = acc_q;
    ovf_d    = ovf_q;
    if (start_w) begin
      len_d = len_i;
      cnt_d = '0;
      acc_d = '0;
      ovf_d = 1'b0;
    end else begin
      if (prod_v_q) begin
        if (sum_w[ACC_W]) begin
          ovf_d = 1'b1;
`ifdef MAC_SAT_EN
          acc_d = '1;
`else
          acc_d = sum_w[ACC_W-1:0];
`endif
        end else begin
          acc_d = sum_w[ACC_W-1:0];
        end
      end
      if (accept_w) begin
        prod_d   = prod_w;
        prod_v_d = 1'b1;
        cnt_d    = cnt_q + 1'b1;
      end
    end
  end

  // datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q    <= '0;
      cnt_q    <= '0;
      prod_q   <= '0;
      prod_v_q <= 1'b0;
      acc_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      prod_q   <= prod_d;
      prod_v_q <= prod_v_d;
      acc_q    <= acc_d;
      ovf_q    <= ovf_d;
    end
  end

  assign acc_out_o = acc_q;
  assign ovf_o     = ovf_q;

endmodule
